// File: rtl/canvas_pkg.sv
// rtl/canvas_pkg.sv - shared state encoding and canvas geometry for the canvas port arbiter
package canvas_pkg;

    localparam int CANVAS_ADDR_W = 10;
    localparam int CANVAS_DEPTH  = 1024;

    localparam logic [1:0] ENC_IDLE  = 2'd0;
    localparam logic [1:0] ENC_RECOG = 2'd1;
    localparam logic [1:0] ENC_CLEAR = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ENC_IDLE,
        RECOG = ENC_RECOG,
        CLEAR = ENC_CLEAR
    } arb_state_t;

endpackage

// File: rtl/canvas_skid1.sv
// rtl/canvas_skid1.sv - one-entry last-wins write buffer with flush and overwrite-drop strobe
module canvas_skid1 #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              load_data,
    input  logic              flush,
    input  logic              drain,
    output logic              valid,
    output logic [ADDR_W-1:0] addr,
    output logic              data,
    output logic              drop
);

    // A held entry that is replaced without having been drained is lost.
    assign drop = load && valid && !drain && !flush;

    // Flush beats load; a load in the same cycle as a drain re-fills the entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            addr  <= '0;
            data  <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            addr  <= load_addr;
            data  <= load_data;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/canvas_port_arbiter.sv
// rtl/canvas_port_arbiter.sv - small_canvas port-A owner (mouse/recognizer/clear); CANVAS_ARB_STATS_EN adds drop_cnt
module canvas_port_arbiter
    import canvas_pkg::*;
#(
    parameter int   ADDR_W    = CANVAS_ADDR_W,
    parameter int   DEPTH     = CANVAS_DEPTH,
    parameter logic CLEAR_VAL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m_we,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic              m_data,
    input  logic              r_req,
    input  logic [ADDR_W-1:0] r_addr,
    output logic              r_gnt,
    output logic              r_data,
    output logic              r_valid,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_d,
    output logic              ram_we,
    input  logic              ram_spo
`ifdef CANVAS_ARB_STATS_EN
    ,
    output logic [15:0]       drop_cnt
`endif
);

    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(DEPTH - 1);

    arb_state_t        state;
    logic              clr_pend;
    logic [ADDR_W-1:0] sweep;

    logic              sk_load;
    logic              sk_flush;
    logic              sk_drain;
    logic              sk_valid;
    logic [ADDR_W-1:0] sk_addr;
    logic              sk_data;
    logic              sk_drop;
    logic              m_discard;

    assign r_gnt    = (state == RECOG) && r_req;
    assign clr_busy = (state == CLEAR) || clr_pend;

    canvas_skid1 #(.ADDR_W(ADDR_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (sk_load),
        .load_addr (m_addr),
        .load_data (m_data),
        .flush     (sk_flush),
        .drain     (sk_drain),
        .valid     (sk_valid),
        .addr      (sk_addr),
        .data      (sk_data),
        .drop      (sk_drop)
    );

    // Port-A mux: who drives the RAM this cycle, and where blocked mouse writes go.
    always_comb begin
        ram_a     = '0;
        ram_d     = 1'b0;
        ram_we    = 1'b0;
        sk_load   = 1'b0;
        sk_flush  = 1'b0;
        sk_drain  = 1'b0;
        m_discard = 1'b0;
        case (state)
            IDLE: begin
                if (clr_start || clr_pend) begin
                    sk_flush  = 1'b1;
                    m_discard = m_we;
                end else if (r_req) begin
                    sk_load = m_we;
                end else if (sk_valid) begin
                    ram_a    = sk_addr;
                    ram_d    = sk_data;
                    ram_we   = 1'b1;
                    sk_drain = 1'b1;
                    sk_load  = m_we;
                end else if (m_we) begin
                    ram_a  = m_addr;
                    ram_d  = m_data;
                    ram_we = 1'b1;
                end
            end
            RECOG: begin
                ram_a   = r_addr;
                sk_load = m_we;
            end
            CLEAR: begin
                ram_a     = sweep;
                ram_d     = CLEAR_VAL;
                ram_we    = 1'b1;
                m_discard = m_we;
            end
            default: ;
        endcase
    end

    // Arbitration FSM with registered read data and clear-done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            clr_pend <= 1'b0;
            sweep    <= '0;
            r_data   <= 1'b0;
            r_valid  <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            r_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_start || clr_pend) begin
                        state <= CLEAR;
                        sweep <= '0;
                    end else if (r_req) begin
                        state <= RECOG;
                    end
                end
                RECOG: begin
                    if (clr_start) begin
                        clr_pend <= 1'b1;
                    end
                    if (r_req) begin
                        r_data  <= ram_spo;
                        r_valid <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                CLEAR: begin
                    if (sweep == LAST_CELL) begin
                        clr_done <= 1'b1;
                        clr_pend <= 1'b0;
                        sweep    <= '0;
                        state    <= IDLE;
                    end else begin
                        sweep <= sweep + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CANVAS_ARB_STATS_EN
    // Saturating count of lost mouse writes, wiped together with the canvas.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (state == CLEAR && sweep == LAST_CELL) begin
            drop_cnt <= '0;
        end else if ((sk_drop || m_discard) && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`else
    logic unused_drop;
    assign unused_drop = sk_drop | m_discard;
`endif

endmodule
